// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration slice: state encoding,
// default sizing and the byte width.
package uart_pkg;

  localparam int BYTE_W            = 8;
  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle between byte producers, the
// arbiter and the shared UART transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      Tx_BUSY;
  logic                      Tx_WR;
  logic [BYTE_W-1:0]         Tx_DATA;

  modport master (
    output req_valid, req_data, Tx_BUSY,
    input  req_grant, Tx_WR, Tx_DATA
  );

  modport slave (
    input  req_valid, req_data, Tx_BUSY,
    output req_grant, Tx_WR, Tx_DATA
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after owner,
// ascending with wrap. Reusable by any shared-resource controller.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   owner,
  output logic               any_valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] pick_s;
  logic             found_s;
  logic             hit_s;

  // Scan owner+1 .. owner+NUM_REQ; the owner itself is visited last.
  always_comb begin
    cand_s  = owner;
    pick_s  = owner;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = IDX_W'((int'(owner) + i) % NUM_REQ);
      hit_s   = !found_s && req_valid[cand_s];
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  assign any_valid = |req_valid;
  assign winner    = pick_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter: issues one Tx_WR per
// granted byte and follows Tx_BUSY through the frame before re-arbitrating.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus,
  output logic [IDX_W-1:0] owner,
  output logic             tx_timeout
);

  localparam int               CNT_W     = $clog2(START_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(START_TIMEOUT);

  arb_state_t          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                tx_wr_r, tx_wr_s;
  logic [BYTE_W-1:0]   tx_data_r, tx_data_s;
  logic [NUM_REQ-1:0]  grant_r, grant_s;
  logic [IDX_W-1:0]    owner_r, owner_s;
  logic                timeout_r, timeout_s;
  logic                any_valid_s;
  logic [IDX_W-1:0]    winner_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid (bus.req_valid),
    .owner     (owner_r),
    .any_valid (any_valid_s),
    .winner    (winner_s)
  );

  // Next state, start-timeout counter and next values of the output registers.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    tx_wr_s   = 1'b0;
    grant_s   = {NUM_REQ{1'b0}};
    tx_data_s = tx_data_r;
    owner_s   = owner_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_valid_s && !bus.Tx_BUSY) begin
          tx_wr_s   = 1'b1;
          grant_s   = NUM_REQ'(1'b1) << winner_s;
          tx_data_s = bus.req_data[int'(winner_s)*BYTE_W +: BYTE_W];
          owner_s   = winner_s;
          cnt_s     = {CNT_W{1'b0}};
          state_s   = WAIT_START;
        end else begin
          state_s   = IDLE;
        end
      end
      WAIT_START: begin
        // Tx_BUSY takes priority over a timeout landing on the same edge.
        if (bus.Tx_BUSY) begin
          cnt_s     = {CNT_W{1'b0}};
          state_s   = WAIT_DONE;
        end else if ((cnt_r + CNT_W'(1'b1)) == CNT_LAST) begin
          cnt_s     = {CNT_W{1'b0}};
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s     = cnt_r + CNT_W'(1'b1);
        end
      end
      WAIT_DONE: begin
        if (!bus.Tx_BUSY) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      tx_wr_r   <= 1'b0;
      tx_data_r <= 8'h00;
      grant_r   <= {NUM_REQ{1'b0}};
      owner_r   <= OWNER_RST;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      tx_wr_r   <= tx_wr_s;
      tx_data_r <= tx_data_s;
      grant_r   <= grant_s;
      owner_r   <= owner_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.Tx_WR     = tx_wr_r;
  assign bus.Tx_DATA   = tx_data_r;
  assign bus.req_grant = grant_r;
  assign owner         = owner_r;
  assign tx_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requesters and a transmitter model are
// stepped once per cycle on the falling edge, writes are matched against a queue.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 16;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] owner;
  logic       tx_timeout;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .owner      (owner),
    .tx_timeout (tx_timeout)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, wr_cyc = 0, req_cyc = 0, fall_cyc = 0, lat_from_fall = 0, wr_age = 100;
  int   busy_delay = 2, busy_len = 10, dly_cnt = 0, hold_cnt = 0;
  bit   model_on = 1'b1, in_frame = 1'b0, prev_wr = 1'b0;
  bit   timeout_mode = 1'b0, to_armed = 1'b0, to_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load(input int idx, input logic [7:0] data);
    exp_t e;
    bus.req_data[8*idx +: 8] = data;
    bus.req_valid[idx]       = 1'b1;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One cycle: advance the transmitter model, then check the DUT outputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) begin
        bus.Tx_BUSY = 1'b1;
        hold_cnt    = busy_len;
      end
    end else if (bus.Tx_BUSY && hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        bus.Tx_BUSY = 1'b0;
        fall_cyc    = cyc;
        in_frame    = 1'b0;
      end
    end
    if (bus.Tx_WR) begin
      chk("double_wr", 32'(prev_wr | in_frame), 32'd0);
      wr_cyc        = cyc;
      lat_from_fall = cyc - fall_cyc;
      wr_age        = 0;
      to_armed      = timeout_mode;
      in_frame      = 1'b1;
      if (model_on) dly_cnt = busy_delay;
      if (exp_q.size() == 0) begin
        chk("unexp_wr", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grant", 32'(bus.req_grant), 32'(1'b1) << e.idx);
        chk("data", 32'(bus.Tx_DATA), 32'(e.data));
        chk("owner", 32'(owner), 32'(e.idx));
      end
      bus.req_valid = bus.req_valid & ~bus.req_grant;
    end else begin
      wr_age++;
      chk("grant_idle", 32'(bus.req_grant), 32'd0);
    end
    chk("timeout", 32'(tx_timeout), 32'(to_armed && wr_age == START_TIMEOUT));
    if (tx_timeout) begin
      to_seen  = 1'b1;
      to_armed = 1'b0;
      in_frame = 1'b0;
    end
    prev_wr = bus.Tx_WR;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame || bus.Tx_BUSY) && n < 400) begin
      step();
      n++;
    end
    chk("drain", 32'(n < 400), 32'd1);
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr"},    32'(bus.Tx_WR),     32'd0);
    chk({tag, "_data"},  32'(bus.Tx_DATA),   32'h00);
    chk({tag, "_grant"}, 32'(bus.req_grant), 32'd0);
    chk({tag, "_owner"}, 32'(owner),         32'd3);
    chk({tag, "_to"},    32'(tx_timeout),    32'd0);
  endtask

  initial begin
    int n;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0;
    bus.Tx_BUSY   = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;

    // All four pending from reset: 0,1,2,3 in order, owner ends at 3.
    load(0, 8'h10); load(1, 8'h21); load(2, 8'h32); load(3, 8'h43);
    drain();
    chk("all4_owner", 32'(owner), 32'd3);

    // Single request, busy rises two cycles after the write and holds 10.
    load(0, 8'hAA);
    req_cyc = cyc;
    drain();
    chk("single_lat", 32'(wr_cyc - req_cyc), 32'd1);

    // Fairness: owner parked at 2, then 1011 pending -> 3, 0, 1.
    load(2, 8'h5C);
    drain();
    chk("fair_owner2", 32'(owner), 32'd2);
    load(3, 8'hD3); load(0, 8'hD0); load(1, 8'hD1);
    drain();
    chk("fair_owner_end", 32'(owner), 32'd1);

    // Busy arriving on the very cycle the counter would expire: no timeout.
    busy_delay = START_TIMEOUT - 1;
    busy_len   = 3;
    load(2, 8'h77);
    drain();
    busy_delay = 2;

    // Busy never rises: timeout pulse exactly START_TIMEOUT cycles after write.
    model_on     = 1'b0;
    timeout_mode = 1'b1;
    load(1, 8'h99);
    n = 0;
    while (!to_seen && n < 60) begin
      step();
      n++;
    end
    chk("to_seen", 32'(to_seen), 32'd1);
    chk("to_age", 32'(wr_age), 32'(START_TIMEOUT));
    timeout_mode = 1'b0;
    model_on     = 1'b1;
    load(3, 8'h3C);
    req_cyc = cyc;
    drain();
    chk("post_to_lat", 32'(wr_cyc - req_cyc), 32'd1);

    // Foreign frame in progress while idle: issue one cycle after busy falls.
    bus.Tx_BUSY = 1'b1;
    hold_cnt    = 6;
    load(2, 8'hB2);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("block_lat", 32'(lat_from_fall), 32'd1);
    drain();

    // Reset in WAIT_DONE while the transmitter is still busy.
    busy_len = 20;
    load(1, 8'hE1);
    n = 0;
    while (!(bus.Tx_BUSY && hold_cnt <= 17) && n < 40) begin
      step();
      n++;
    end
    chk("mid_frame_reached", 32'(bus.Tx_BUSY), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;
    busy_len = 4;
    load(0, 8'hF0); load(1, 8'hF1); load(3, 8'hF3);
    n = 0;
    while (exp_q.size() == 3 && n < 60) begin
      step();
      n++;
    end
    chk("midrst_lat", 32'(lat_from_fall), 32'd1);
    drain();
    chk("midrst_owner_end", 32'(owner), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
